// File: rtl/roll_ctrl_pkg.sv
// Shared types and constants for the roll-button dice animation sequencer.
package roll_ctrl_pkg;

   localparam int unsigned TimerW = 32;

   typedef enum logic [1:0] {
      StIdle,
      StSpin,
      StLock
   } roll_state_e;

endpackage

// File: rtl/roll_frame_timer.sv
// Frame timer for the dice spin: counts cycles per frame, decelerating when
// ROLL_CTRL_DECEL_EN is defined, and flags the final frame of a roll.
module roll_frame_timer #(
   parameter int unsigned FRAME_CYCLES = 5_000_000,
   parameter int unsigned SPIN_FRAMES  = 20,
   parameter int unsigned DECEL_STEP   = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   output logic frame_tick,
   output logic last_frame
);
   import roll_ctrl_pkg::*;

   localparam int unsigned FrameW = $clog2(SPIN_FRAMES + 1);

`ifdef ROLL_CTRL_DECEL_EN
   localparam longint unsigned MaxPeriod =
      64'(FRAME_CYCLES) + 64'(SPIN_FRAMES - 1) * 64'(DECEL_STEP);
`else
   localparam longint unsigned MaxPeriod = 64'(FRAME_CYCLES);
   logic unused_decel;
   assign unused_decel = ^DECEL_STEP;
`endif

   if (MaxPeriod >= 64'h1_0000_0000 || FRAME_CYCLES < 2 || SPIN_FRAMES < 1) begin : g_bad_cfg
      $error("roll_frame_timer: invalid FRAME_CYCLES/SPIN_FRAMES/DECEL_STEP");
   end

   logic [TimerW-1:0] timer;
   logic [TimerW-1:0] period;
   logic [FrameW-1:0] frame;

   assign frame_tick = run && (timer == period - TimerW'(1));
   assign last_frame = (frame == FrameW'(SPIN_FRAMES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         timer  <= '0;
         period <= TimerW'(FRAME_CYCLES);
         frame  <= '0;
      end else if (start) begin
         timer  <= '0;
         period <= TimerW'(FRAME_CYCLES);
         frame  <= '0;
      end else if (frame_tick) begin
         timer <= '0;
         frame <= frame + FrameW'(1);
`ifdef ROLL_CTRL_DECEL_EN
         period <= period + TimerW'(DECEL_STEP);
`endif
      end else if (run) begin
         timer <= timer + TimerW'(1);
      end
   end

endmodule

// File: rtl/roll_controller.sv
// Roll-button sequencer: seeds the RNG once, animates four dice digits at a
// frame rate set by roll_frame_timer (decelerating under ROLL_CTRL_DECEL_EN).
module roll_controller #(
   parameter int unsigned FRAME_CYCLES = 5_000_000,
   parameter int unsigned SPIN_FRAMES  = 20,
   parameter int unsigned DECEL_STEP   = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_roll,
   input  logic [3:0] hold,
   input  logic [3:0] rng_d0,
   input  logic [3:0] rng_d1,
   input  logic [3:0] rng_d2,
   input  logic [3:0] rng_d3,
   output logic       seed_en,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic       rolling,
   output logic       done
);
   import roll_ctrl_pkg::*;

   roll_state_e state;
   logic        prev_btn;
   logic        seeded;
   logic        roll_edge;
   logic        start;
   logic        run;
   logic        frame_tick;
   logic        last_frame;

   assign roll_edge = btn_roll & ~prev_btn;
   assign start     = (state == StIdle) && roll_edge;
   assign run       = (state == StSpin);

   roll_frame_timer #(
      .FRAME_CYCLES (FRAME_CYCLES),
      .SPIN_FRAMES  (SPIN_FRAMES),
      .DECEL_STEP   (DECEL_STEP)
   ) u_frame_timer (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .run        (run),
      .frame_tick (frame_tick),
      .last_frame (last_frame)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         prev_btn <= 1'b0;
         seeded   <= 1'b0;
         seed_en  <= 1'b0;
         rolling  <= 1'b0;
         done     <= 1'b0;
         digit0   <= '0;
         digit1   <= '0;
         digit2   <= '0;
         digit3   <= '0;
      end else begin
         // Edge history runs in every state so a held button never retriggers.
         prev_btn <= btn_roll;
         seed_en  <= 1'b0;
         done     <= 1'b0;
         unique case (state)
            StIdle: begin
               if (roll_edge) begin
                  state   <= StSpin;
                  rolling <= 1'b1;
                  if (!seeded) begin
                     seeded  <= 1'b1;
                     seed_en <= 1'b1;
                  end
               end
            end
            StSpin: begin
               if (frame_tick) begin
                  if (!hold[0]) digit0 <= rng_d0;
                  if (!hold[1]) digit1 <= rng_d1;
                  if (!hold[2]) digit2 <= rng_d2;
                  if (!hold[3]) digit3 <= rng_d3;
                  if (last_frame) begin
                     state   <= StLock;
                     rolling <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            StLock: begin
               state <= StIdle;
            end
            default: begin
               state   <= StIdle;
               rolling <= 1'b0;
            end
         endcase
      end
   end

endmodule
